// File: rtl/ofs_plat_prim_vchan_req_rsp_mux_if.sv
// Handshake bundle for the virtual-channel request/response mux.
// slave: seen by the mux; master: seen by the sources/sink around it.
interface ofs_plat_prim_vchan_req_rsp_mux_if #(
    parameter int NUM_PORTS = 2,
    parameter int REQ_WIDTH = 64,
    parameter int RSP_WIDTH = 66,
    parameter int VCHAN_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);
    logic [NUM_PORTS-1:0]           src_req_valid;
    logic [NUM_PORTS-1:0]           src_req_ready;
    logic [NUM_PORTS*REQ_WIDTH-1:0] src_req_data;
    logic [NUM_PORTS-1:0]           src_rsp_valid;
    logic [NUM_PORTS-1:0]           src_rsp_ready;
    logic [RSP_WIDTH-1:0]           src_rsp_data;
    logic                           snk_req_valid;
    logic                           snk_req_ready;
    logic [REQ_WIDTH-1:0]           snk_req_data;
    logic [VCHAN_W-1:0]             snk_req_vchan;
    logic                           snk_rsp_valid;
    logic                           snk_rsp_ready;
    logic [RSP_WIDTH-1:0]           snk_rsp_data;
    logic                           err_orphan_rsp;

    modport slave (
        input  src_req_valid, src_req_data, src_rsp_ready,
        input  snk_req_ready, snk_rsp_valid, snk_rsp_data,
        output src_req_ready, src_rsp_valid, src_rsp_data,
        output snk_req_valid, snk_req_data, snk_req_vchan,
        output snk_rsp_ready, err_orphan_rsp
    );

    modport master (
        output src_req_valid, src_req_data, src_rsp_ready,
        output snk_req_ready, snk_rsp_valid, snk_rsp_data,
        input  src_req_ready, src_rsp_valid, src_rsp_data,
        input  snk_req_valid, snk_req_data, snk_req_vchan,
        input  snk_rsp_ready, err_orphan_rsp
    );
endinterface

// File: rtl/ofs_plat_prim_vchan_req_rsp_mux.sv
// Round-robin N:1 request mux with vchan tagging and in-order response return.
// Optional orphan-response drop/flag: OFS_PLAT_VCHAN_MUX_ORPHAN_RSP_CHECK_EN.
module ofs_plat_prim_vchan_req_rsp_mux #(
    parameter int NUM_PORTS       = 2,
    parameter int REQ_WIDTH       = 64,
    parameter int RSP_WIDTH       = 66,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic clk,
    input  logic reset,
    ofs_plat_prim_vchan_req_rsp_mux_if.slave bus
);
    localparam int VCHAN_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PTR_W   = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W   = PTR_W + 1;

    logic                 out_valid_q;
    logic [REQ_WIDTH-1:0] out_data_q;
    logic [VCHAN_W-1:0]   out_vchan_q;
    logic [VCHAN_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [VCHAN_W-1:0]   tag_q [MAX_OUTSTANDING];

    logic                 arb_found;
    logic [VCHAN_W-1:0]   arb_idx;
    logic [REQ_WIDTH-1:0] arb_data;
    int                   arb_sum;
    logic                 can_issue, grant, pop, fifo_empty;
    logic [VCHAN_W-1:0]   head;

    assign fifo_empty = (cnt_q == '0);
    assign head       = tag_q[rd_ptr_q];
    assign can_issue  = !reset && (!out_valid_q || bus.snk_req_ready)
                        && (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign grant      = arb_found && can_issue;
    assign pop        = bus.snk_rsp_valid && bus.snk_rsp_ready && !fifo_empty;

    // Round-robin search for the first valid port at or after the pointer
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            arb_sum = int'(rr_ptr_q) + i;
            if (arb_sum >= NUM_PORTS) arb_sum = arb_sum - NUM_PORTS;
            if (!arb_found && bus.src_req_valid[VCHAN_W'(arb_sum)]) begin
                arb_found = 1'b1;
                arb_idx   = VCHAN_W'(arb_sum);
            end
        end
    end

    // Select granted payload and drive per-port ready/valid
    always_comb begin
        arb_data          = '0;
        bus.src_req_ready = '0;
        bus.src_rsp_valid = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (arb_idx == VCHAN_W'(p))
                arb_data = bus.src_req_data[p*REQ_WIDTH +: REQ_WIDTH];
            bus.src_req_ready[p] = grant && (arb_idx == VCHAN_W'(p));
            bus.src_rsp_valid[p] = bus.snk_rsp_valid && !fifo_empty
                                   && (head == VCHAN_W'(p));
        end
    end

    // Response ready follows the port at the FIFO head; orphans may be dropped
    always_comb begin
        bus.snk_rsp_ready = !reset && !fifo_empty && bus.src_rsp_ready[head];
`ifdef OFS_PLAT_VCHAN_MUX_ORPHAN_RSP_CHECK_EN
        if (!reset && fifo_empty && bus.snk_rsp_valid)
            bus.snk_rsp_ready = 1'b1;
`endif
    end

    // Next pointer and outstanding count
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant)
            rr_ptr_d = (arb_idx == VCHAN_W'(NUM_PORTS - 1)) ? '0 : arb_idx + 1'b1;
        cnt_d = cnt_q;
        if (grant && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!grant && pop) cnt_d = cnt_q - 1'b1;
    end

    // Output register, tag FIFO and arbiter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_vchan_q <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            if (grant) begin
                out_valid_q     <= 1'b1;
                out_data_q      <= arb_data;
                out_vchan_q     <= arb_idx;
                tag_q[wr_ptr_q] <= arb_idx;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end else if (bus.snk_req_ready) begin
                out_valid_q <= 1'b0;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

`ifdef OFS_PLAT_VCHAN_MUX_ORPHAN_RSP_CHECK_EN
    logic err_q, err_d;

    assign err_d = err_q || (fifo_empty && bus.snk_rsp_valid);

    // Sticky flag for a response arriving with nothing outstanding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign bus.err_orphan_rsp = err_q;
`else
    assign bus.err_orphan_rsp = 1'b0;
`endif

    assign bus.snk_req_valid = out_valid_q;
    assign bus.snk_req_data  = out_data_q;
    assign bus.snk_req_vchan = out_vchan_q;
    assign bus.src_rsp_data  = bus.snk_rsp_data;
endmodule
